// File: rtl/ps_window_detect.sv
// ps_window_detect: windowed power averager and threshold detector.
// Accumulates 2^win_log2 valid samples (negative samples clamped to 0),
// publishes the window average on avg_out with a one-cycle avg_valid pulse,
// and raises detect after hold_cnt consecutive windows above thresh.
// Optional feature macro: PS_WIN_HYST_EN -- when defined, detect uses a
// hysteresis counter (below windows decrement instead of clearing).
module ps_window_detect #(
  parameter int input_width = 33,
  parameter int win_log2    = 8,
  parameter int hold_cnt    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [input_width-1:0] din,
  input  logic                   din_valid,
  input  logic [input_width-1:0] thresh,
  output logic [input_width-1:0] avg_out,
  output logic                   avg_valid,
  output logic                   detect
);

  localparam int ACC_W = input_width + win_log2;
  localparam logic [7:0] HOLD8 = 8'(hold_cnt);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [win_log2-1:0]    cnt_q, cnt_d;
  logic [7:0]             above_q, above_d;
  logic [input_width-1:0] avg_out_q, avg_out_d;
  logic                   avg_valid_q, avg_valid_d;
  logic                   detect_q, detect_d;

  // Conditioned sample: negative power readings contribute nothing.
  logic [input_width-1:0] din_clamp;
  logic [ACC_W-1:0]       sample_ext;
  logic [input_width-1:0] avg_new;

  // Sample conditioning and the average of the window just closed.
  always_comb begin
    din_clamp  = din[input_width-1] ? '0 : din;
    sample_ext = {{win_log2{1'b0}}, din_clamp};
    avg_new    = acc_q[ACC_W-1:win_log2];
  end

  // Next-state, datapath and output computation for the window FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    above_d     = above_q;
    avg_out_d   = avg_out_q;
    avg_valid_d = 1'b0;
    detect_d    = detect_q;

    case (state_q)
      S_IDLE: begin
        acc_d    = '0;
        cnt_d    = '0;
        above_d  = '0;
        detect_d = 1'b0;
        if (en) state_d = S_ACCUM;
      end

      S_ACCUM: begin
        if (!en) begin
          // Partial window is thrown away; no average is produced.
          state_d  = S_IDLE;
          acc_d    = '0;
          cnt_d    = '0;
          above_d  = '0;
          detect_d = 1'b0;
        end else if (din_valid) begin
          acc_d = acc_q + sample_ext;
          cnt_d = cnt_q + win_log2'(1);
          if (&cnt_q) state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        avg_out_d   = avg_new;
        avg_valid_d = 1'b1;

        if (avg_new > thresh) begin
          above_d = (above_q >= HOLD8) ? HOLD8 : above_q + 8'd1;
        end else begin
`ifdef PS_WIN_HYST_EN
          // While detecting, each quiet window only backs the count off by one.
          if (detect_q && (above_q != 8'd0)) above_d = above_q - 8'd1;
          else                                above_d = 8'd0;
`else
          above_d = 8'd0;
`endif
        end

`ifdef PS_WIN_HYST_EN
        detect_d = detect_q ? (above_d != 8'd0) : (above_d >= HOLD8);
`else
        detect_d = (above_d >= HOLD8);
`endif

        // A sample arriving in this cycle opens the next window.
        if (en && din_valid) begin
          acc_d = sample_ext;
          cnt_d = win_log2'(1);
        end else begin
          acc_d = '0;
          cnt_d = '0;
        end
        state_d = en ? S_ACCUM : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      above_q     <= '0;
      avg_out_q   <= '0;
      avg_valid_q <= 1'b0;
      detect_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      above_q     <= above_d;
      avg_out_q   <= avg_out_d;
      avg_valid_q <= avg_valid_d;
      detect_q    <= detect_d;
    end
  end

  assign avg_out   = avg_out_q;
  assign avg_valid = avg_valid_q;
  assign detect    = detect_q;

endmodule

// File: tb/tb_ps_window_detect.sv
// Testbench for ps_window_detect (win_log2=2, hold_cnt=2, input_width=33).
// Directed scenarios followed by randomized traffic, every cycle compared
// against a window-level reference model kept in this file.
module tb_ps_window_detect;

  localparam int IW  = 33;
  localparam int WL  = 2;
  localparam int HC  = 2;
  localparam int WIN = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [IW-1:0] din;
  logic          din_valid;
  logic [IW-1:0] thresh;
  logic [IW-1:0] avg_out;
  logic          avg_valid;
  logic          detect;

  int checks = 0;
  int errors = 0;

  // Reference model state: samples of the open window, window verdict history.
  bit            m_run;
  longint        m_win[$];
  bit            m_pend;
  bit            m_hist[$];
  int            m_cnt;
  logic [IW-1:0] m_avg;
  bit            m_valid;
  bit            m_det;

  ps_window_detect #(
    .input_width(IW),
    .win_log2   (WL),
    .hold_cnt   (HC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .din_valid(din_valid),
    .thresh   (thresh),
    .avg_out  (avg_out),
    .avg_valid(avg_valid),
    .detect   (detect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input logic [IW-1:0] d);
    return d[IW-1] ? 64'sd0 : longint'(d);
  endfunction

  task automatic model_reset();
    m_run = 0; m_win.delete(); m_pend = 0; m_hist.delete();
    m_cnt = 0; m_avg = '0; m_valid = 0; m_det = 0;
  endtask

  // One clock edge of the model, using the inputs presented for that edge.
  task automatic model_edge();
    longint sum;
    bit     above;
    m_valid = 0;
    if (m_pend) begin
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      m_avg   = IW'(sum / WIN);
      m_valid = 1;
      above   = (sum / WIN) > longint'(thresh);
      m_pend  = 0;
`ifdef PS_WIN_HYST_EN
      if (above)      m_cnt = (m_cnt + 1 > HC) ? HC : m_cnt + 1;
      else if (m_det) m_cnt = m_cnt - 1;
      else            m_cnt = 0;
      m_det = m_det ? (m_cnt != 0) : (m_cnt >= HC);
`else
      m_hist.push_back(above);
      m_det = (m_hist.size() >= HC);
      for (int k = 0; k < HC; k++)
        if (m_hist.size() > k && !m_hist[m_hist.size()-1-k]) m_det = 0;
`endif
      m_win.delete();
      if (en && din_valid) m_win.push_back(clampv(din));
    end else if (!m_run || !en) begin
      m_win.delete(); m_hist.delete(); m_cnt = 0; m_det = 0;
    end else if (din_valid) begin
      m_win.push_back(clampv(din));
      if (m_win.size() == WIN) m_pend = 1;
    end
    m_run = en;
  endtask

  task automatic step(input bit e, input bit v, input logic [IW-1:0] d);
    en = e; din_valid = v; din = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("avg_out",   64'(avg_out),   64'(m_avg));
    chk("avg_valid", 64'(avg_valid), 64'(m_valid));
    chk("detect",    64'(detect),    64'(m_det));
  endtask

  task automatic window(input logic [IW-1:0] d);
    repeat (WIN) step(1, 1, d);
    step(1, 0, '0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_avg_out",   64'(avg_out),   64'd0);
    chk("arst_avg_valid", 64'(avg_valid), 64'd0);
    chk("arst_detect",    64'(detect),    64'd0);
    #2 rst = 1'b1;
  endtask

  initial begin
    model_reset();
    rst = 1'b0; en = 1'b0; din_valid = 1'b0; din = '0; thresh = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom); din_valid = 1'($urandom); din = {1'($urandom), $urandom()};
      thresh = {1'b0, $urandom()};
      @(posedge clk); #1;
      chk("rst_avg_out",   64'(avg_out),   64'd0);
      chk("rst_avg_valid", 64'(avg_valid), 64'd0);
      chk("rst_detect",    64'(detect),    64'd0);
    end
    #2 rst = 1'b1;

    // Steady input: 8 back-to-back samples of 100, thresh 50.
    thresh = 33'd50;
    step(1, 0, '0);
    repeat (4) step(1, 1, 33'd100);
    step(1, 1, 33'd100);
    chk("steady1_avg",   64'(avg_out),   64'd100);
    chk("steady1_valid", 64'(avg_valid), 64'd1);
    chk("steady1_det",   64'(detect),    64'd0);
    step(1, 1, 33'd100);
    chk("steady_pulse_width", 64'(avg_valid), 64'd0);
    repeat (2) step(1, 1, 33'd100);
    step(1, 0, '0);
    chk("steady2_avg",   64'(avg_out),   64'd100);
    chk("steady2_valid", 64'(avg_valid), 64'd1);
    chk("steady2_det",   64'(detect),    64'd1);

    // Reset asserted mid-window while detect is high.
    step(1, 1, 33'd7);
    step(1, 1, 33'd7);
    async_reset();

    // Clamping and gaps: -50, 10, 20, 30 with din_valid every other cycle.
    step(1, 0, '0);
    step(1, 1, -50); step(1, 0, '0);
    step(1, 1, 10);  step(1, 0, '0);
    step(1, 1, 20);  step(1, 0, '0);
    step(1, 1, 30);
    chk("clamp_no_early_pulse", 64'(avg_valid), 64'd0);
    step(1, 0, '0);
    chk("clamp_avg",   64'(avg_out),   64'd15);
    chk("clamp_valid", 64'(avg_valid), 64'd1);

    // Abort: partial window of two samples discarded by en low.
    step(1, 1, 33'd100);
    step(1, 1, 33'd100);
    step(0, 0, '0);
    chk("abort_no_pulse", 64'(avg_valid), 64'd0);
    step(1, 0, '0);
    window(33'd8);
    chk("abort_avg",   64'(avg_out),   64'd8);
    chk("abort_valid", 64'(avg_valid), 64'd1);
    chk("abort_det",   64'(detect),    64'd0);

    // Hysteresis behaviour around a single quiet window.
    window(33'd100);
    window(33'd100);
    chk("hyst_set_det", 64'(detect), 64'd1);
    window(33'd10);
`ifdef PS_WIN_HYST_EN
    chk("hyst_low_det", 64'(detect), 64'd1);
`else
    chk("hyst_low_det", 64'(detect), 64'd0);
`endif
    window(33'd100);
`ifdef PS_WIN_HYST_EN
    chk("hyst_recover_det", 64'(detect), 64'd1);
`else
    chk("hyst_recover_det", 64'(detect), 64'd0);
`endif

    // Extremes: full-scale positive samples average without wrap.
    window(33'h0_FFFF_FFFF);
    chk("extreme_avg", 64'(avg_out), 64'd4294967295);

    // Sample in the UPDATE cycle belongs to the next window.
    repeat (WIN) step(1, 1, 33'd20);
    step(1, 1, 33'd60);
    chk("boundary_avg1", 64'(avg_out), 64'd20);
    repeat (WIN - 1) step(1, 1, 33'd60);
    step(1, 0, '0);
    chk("boundary_avg2",   64'(avg_out),   64'd60);
    chk("boundary_valid2", 64'(avg_valid), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(149) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(19) == 0)
          thresh = ($urandom_range(1) == 1) ? {1'b0, $urandom()} : 33'd0;
        step(($urandom_range(24) != 0), ($urandom_range(3) != 0),
             {($urandom_range(3) == 0), $urandom()});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps_window_detect.md
# ps_window_detect

Windowed power averager and threshold detector. It sits directly downstream of `ps_comp_unit` and consumes that unit's signed power samples (`dout`/`data_valid`). It accumulates a window of 2^`win_log2` valid samples, outputs the window average, and raises `detect` after `hold_cnt` consecutive windows whose average exceeds a runtime threshold.

## Interface
- `input_width`, 33: width of `din`, `thresh` and `avg_out`; matches `ps_comp_unit` output width.
- `win_log2`, 8: log2 of the window length in valid samples; legal range 1..16.
- `hold_cnt`, 4: number of consecutive above-threshold windows required to assert `detect`; legal range 1..255.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `en` input 1: block enable.
- `din` input `input_width`: signed power sample.
- `din_valid` input 1: `din` qualifier, one sample per cycle.
- `thresh` input `input_width`: unsigned threshold, compared against the average.
- `avg_out` output `input_width`: unsigned window average, held between updates.
- `avg_valid` output 1: one-cycle pulse marking a new `avg_out`.
- `detect` output 1: detection flag, level.

## Operation
- Accumulator width is `input_width`+`win_log2`; it cannot overflow.
- Sample count width is `win_log2`.
- Above-count width is 8 bits, saturating at `hold_cnt`.
- Input conditioning: a negative `din` is clamped to 0 before accumulation.
- IDLE state:
  - Entered from reset, or from any state when `en`=0.
  - Accumulator and sample count are cleared.
  - `avg_out` is held.
  - Above-count and `detect` are cleared.
  - `din_valid` is ignored.
  - `en`=1 → ACCUM on the next edge.
- ACCUM state:
  - On each edge with `din_valid`=1, acc += clamp(din) and count increments.
  - When the sample accepted is count = 2^`win_log2`-1, go to UPDATE.
- UPDATE state (exactly one cycle):
  - `avg_out` <= acc >> `win_log2`, truncated toward zero; `avg_valid` <= 1.
  - If `avg_out`_new > `thresh`: above-count increments, saturating at `hold_cnt`. Otherwise above-count is cleared (see Configuration).
  - `detect` <= (above-count_new >= `hold_cnt`).
  - acc is loaded with clamp(`din`) if `din_valid`=1, else 0. Count is loaded with `din_valid`. No sample is lost across the window boundary.
  - Next state is ACCUM if `en`=1, else IDLE.
- `en` falling mid-window: the partial window is discarded on the next edge and no `avg_valid` is produced.
- `thresh` is sampled only in UPDATE. Changing it mid-window is legal.
- `rst` low, at any time and asynchronously: state → IDLE; acc, count, above-count, `avg_out`, `avg_valid` and `detect` all go to 0.

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `detect`=0.
- Latency: the last sample of a window is accepted at edge N. `avg_out`, `avg_valid` and `detect` update at edge N+1. `avg_valid` deasserts at edge N+2.
- Throughput: full rate. `din_valid` may be high every cycle, including the UPDATE cycle.
- Gaps in `din_valid` stall the window count only; they add no other delay.
- All outputs are registered. There is no combinational path from inputs to outputs.
- First `avg_valid` after `en` rises: no earlier than 2^`win_log2`+1 edges after the IDLE→ACCUM edge.

## Configuration
- Macro: `PS_WIN_HYST_EN`.
- Defined:
  - Once `detect`=1, a below-threshold window decrements above-count instead of clearing it.
  - `detect` clears only when above-count reaches 0, which is `hold_cnt` consecutive below windows.
  - `detect` sets again when above-count reaches `hold_cnt`.
  - While `detect`=0, behaviour is identical to the macro undefined.
- Undefined: the first below-threshold window clears above-count, and `detect` falls at that UPDATE.

## Test plan
Bench parameters: `win_log2`=2, `hold_cnt`=2, `input_width`=33.
- Reset: hold `rst`=0 with random inputs → `avg_out`=0, `avg_valid`=0, `detect`=0. Asserting `rst` mid-window also forces all three to 0 immediately.
- Steady input: `en`=1, `thresh`=50, `din`=100 valid ×8 back-to-back.
  - Edge after the 4th sample: `avg_out`=100, `avg_valid` pulses for 1 cycle, `detect`=0.
  - Edge after the 8th sample: second pulse with `avg_out`=100, `detect`=1.
- Clamping and gaps: samples -50, 10, 20, 30, with `din_valid` high every other cycle → `avg_out`=15, with the pulse exactly one edge after the 4th valid sample.
- Abort: `en` dropped after 2 samples of 100, then re-raised with 4×8 → no pulse for the partial window, next `avg_out`=8, `detect`=0.
- Hysteresis: reach `detect`=1 as in the steady-input scenario, then feed one window of 4×10 followed by one window of 4×100.
  - Macro undefined: `detect` falls at the low window's UPDATE and stays 0 after the next window of 100.
  - Macro defined: `detect` stays 1 throughout.
- Extremes: `din`=2^32-1 ×4 → `avg_out`=4294967295 with no wrap. A sample presented in the UPDATE cycle is counted in the next window, and that window averages correctly.
